gam_pattern_loader: RTL and testbench
=====================================

Name: gam_pattern_loader

Overview:
- Sits directly upstream of Memory_Layer.
- Accepts packed {class, node vector} records from the input pipe/stream side and buffers them in a small FIFO.
- Presents one record at a time as x/c, using Memory_Layer's READY/WAIT handshake.
- Sequences the LEARNING → RECALL → done phases; this replaces ad-hoc testbench sequencing with synthesizable RTL.

Parameters:
- VECTOR_LEN, 8: node vector length in bytes; x width = VECTOR_LEN*8.
- FIFO_DEPTH, 4: record buffer depth; power of 2, ≥ 2.
- CNT_W, 16: width of the pattern counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream record valid.
- in_ready  output  1  loader can accept a record this cycle.
- in_data  input  VECTOR_LEN*8+32  record; [VECTOR_LEN*8-1:0] = vector, [VECTOR_LEN*8+31:VECTOR_LEN*8] = class.
- in_eom  input  1  marks the last record of the current phase; qualified by in_valid & in_ready.
- ml_ready  input  1  1 = Memory_Layer READY, 0 = WAIT.
- x  output  VECTOR_LEN*8  presented node vector.
- c  output  32  presented class; 0 in recall phase.
- x_valid  output  1  x/c hold a valid record.
- learning_recall  output  1  0 = LEARNING, 1 = RECALL.
- learning_done  output  1  all learning records consumed.
- all_done  output  1  recall stream fully consumed; sticky.
- learn_count  output  CNT_W  learning records consumed.
- recall_count  output  CNT_W  recall records consumed.
- err_zero  output  1  sticky; a record was dropped because its vector was 0, or its class was 0 during learning.

Behaviour:
- Reset (async, reset=0): FIFO empty; state LEARN.
  - x=0, c=0, x_valid=0, learning_recall=0, learning_done=0, all_done=0, counts=0, err_zero=0, in_ready=0.
  - After reset deassertion, in_ready follows the rules below from the first clk edge.
- Accept condition: in_valid & in_ready.
  - in_ready = !fifo_full & (state==LEARN | state==RECALL) & !eom_seen_this_phase.
- Zero filter at the accept point:
  - Drop the record if vector==0, or if state==LEARN and class==0. Set err_zero.
  - A dropped record that carries in_eom still ends the phase: the eom flag attaches to the last stored record; if the FIFO is empty, the phase ends immediately.
- Stored entry = {vector, class, eom}.
- Output register: x/c/x_valid are registered.
  - Consumption = x_valid & ml_ready at a rising edge.
  - When the output register is empty or being consumed, it loads the FIFO head on the same edge.
  - Record accepted at edge N with FIFO and output empty → x_valid=1 after edge N+1. Minimum latency 1 cycle.
  - Sustained throughput is 1 record per cycle while ml_ready=1.
- Hold rule: while x_valid=1 and ml_ready=0, x and c are stable.
- Simultaneous accept and consume on a full FIFO: in_ready is already 0, so there is no push; the pop frees a slot and in_ready rises the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.
- State machine:
  - LEARN: presents records with c = record class. Each consumption increments learn_count.
    - When the consumed record has eom: learning_done=1, learning_recall=1, go to RECALL on the next cycle.
    - Records arriving after eom are blocked by the eom_seen gate until the phase switch.
  - RECALL: presents records with c=0. Each consumption increments recall_count.
    - When the consumed record has eom: all_done=1, go to DONE.
  - DONE: in_ready=0, x_valid=0. Outputs and counts hold until reset.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- learning_done and all_done are sticky until reset.
- Reset mid-operation: all state, including buffered records, is discarded immediately (async).

Test Plan:
- Three learning records (class 1,2,3; vectors 0x01..,0x02..,0x03..; eom on the third), ml_ready=1 constant → x/c appear in order one cycle after each accept. learning_done=1 and learning_recall=1 after the 3rd consumption; learn_count=3.
- ml_ready=0 for 10 cycles while 6 records are offered → exactly FIFO_DEPTH+1=5 accepted; in_ready=0 thereafter; x/c stable. Release ml_ready → all 5 consumed in order, then the 6th accepted.
- Learning record with class=0 and another with vector=0 → both dropped, err_zero=1, learn_count excludes them. A subsequent valid record is presented normally.
- After learning, 2 recall records (second with eom) carrying class 7 → presented with c=0. recall_count=2, all_done=1, in_ready=0 thereafter.
- Dropped zero-vector record carrying eom with FIFO empty → phase switches to RECALL without any consumption.
- Assert reset for one cycle while 3 records are buffered and x_valid=1 → outputs go to reset values asynchronously; after release, learning restarts with counts=0.

Source files
------------

// File: rtl/gam_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : gam_pattern_loader
// Purpose  : Feeds Memory_Layer one {class, node vector} record at a time.
//            Records arrive on a valid/ready stream and are buffered in a
//            small FIFO. They are then presented on x/c through a registered
//            output stage that follows Memory_Layer's READY/WAIT handshake.
//            The loader steps through LEARNING -> RECALL -> DONE. Each phase
//            ends when the record marked end-of-message is consumed.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   in_valid        in   upstream record valid
//   in_ready        out  loader accepts a record this cycle
//   in_data         in   {class[31:0], vector[VECTOR_LEN*8-1:0]}
//   in_eom          in   last record of the current phase
//   ml_ready        in   1 = Memory_Layer READY, 0 = WAIT
//   x               out  presented node vector
//   c               out  presented class (0 during recall)
//   x_valid         out  x/c hold a valid record
//   learning_recall out  0 = LEARNING, 1 = RECALL
//   learning_done   out  all learning records consumed (sticky)
//   all_done        out  recall stream consumed (sticky)
//   learn_count     out  learning records consumed (saturating)
//   recall_count    out  recall records consumed (saturating)
//   err_zero        out  sticky; a zero vector/class record was dropped
// ============================================================================
module gam_pattern_loader #(
  parameter int VECTOR_LEN = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VECTOR_LEN*8+31:0]  in_data,
  input  logic                      in_eom,
  input  logic                      ml_ready,
  output logic [VECTOR_LEN*8-1:0]   x,
  output logic [31:0]               c,
  output logic                      x_valid,
  output logic                      learning_recall,
  output logic                      learning_done,
  output logic                      all_done,
  output logic [CNT_W-1:0]          learn_count,
  output logic [CNT_W-1:0]          recall_count,
  output logic                      err_zero
);

  localparam int VW = VECTOR_LEN * 8;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_LEARN  = 2'd0,
    ST_RECALL = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_started;
  logic             r_eom_seen;
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [VW-1:0]    r_mem_vec [FIFO_DEPTH];
  logic [31:0]      r_mem_cls [FIFO_DEPTH];
  logic             r_mem_eom [FIFO_DEPTH];
  logic [VW-1:0]    r_x;
  logic [31:0]      r_c;
  logic             r_x_valid;
  logic             r_out_eom;
  logic             r_learning_recall;
  logic             r_learning_done;
  logic             r_all_done;
  logic [CNT_W-1:0] r_learn_count;
  logic [CNT_W-1:0] r_recall_count;
  logic             r_err_zero;

  logic [VW-1:0]    w_vec;
  logic [31:0]      w_cls;
  logic [PW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_active;
  logic             w_accept;
  logic             w_zero;
  logic             w_push;
  logic             w_drop_eom;
  logic             w_consume;
  logic             w_pop;
  logic             w_last_in_head;
  logic             w_out_held;
  logic             w_attach_mem;
  logic             w_attach_load;
  logic             w_attach_out;
  logic             w_end_now;
  logic             w_phase_end;
  logic [PW-1:0]    w_rd_idx;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_last_idx;

  assign w_vec    = in_data[VW-1:0];
  assign w_cls    = in_data[VW+31:VW];

  assign w_rd_idx   = r_rd_ptr[PW-1:0];
  assign w_wr_idx   = r_wr_ptr[PW-1:0];
  assign w_last_idx = w_wr_idx - PW'(1);
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                      (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  assign w_active = (r_state == ST_LEARN) || (r_state == ST_RECALL);

  // r_started holds in_ready low until the first edge after reset release.
  assign in_ready = r_started && !w_full && w_active && !r_eom_seen;
  assign w_accept = in_valid && in_ready;

  // During learning a zero class is also meaningless, so it is filtered too.
  assign w_zero     = (w_vec == '0) || ((r_state == ST_LEARN) && (w_cls == '0));
  assign w_push     = w_accept && !w_zero;
  assign w_drop_eom = w_accept && w_zero && in_eom;

  assign w_consume  = r_x_valid && ml_ready;
  assign w_pop      = !w_empty && (!r_x_valid || ml_ready) && w_active;
  assign w_out_held = r_x_valid && !ml_ready;

  // A dropped end-of-message record moves its eom onto the most recently
  // stored record. That record sits in one of three places:
  //  - in the FIFO memory at wr_ptr-1;
  //  - in the FIFO head, being moved into the output register on this very
  //    edge, where a memory write would be missed;
  //  - in the output register, still waiting (FIFO empty).
  // If there is no such record, the phase ends right away.
  assign w_last_in_head = (w_count == (PW+1)'(1)) && w_pop;
  assign w_attach_mem   = w_drop_eom && !w_empty && !w_last_in_head;
  assign w_attach_load  = w_drop_eom && w_last_in_head;
  assign w_attach_out   = w_drop_eom && w_empty && w_out_held;
  assign w_end_now      = w_drop_eom && w_empty && !w_out_held;

  assign w_phase_end = (w_consume && r_out_eom) || w_end_now;

  // Record storage carries no reset; the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_vec[w_wr_idx] <= w_vec;
      r_mem_cls[w_wr_idx] <= w_cls;
      r_mem_eom[w_wr_idx] <= in_eom;
    end
    if (w_attach_mem) begin
      r_mem_eom[w_last_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= ST_LEARN;
      r_started         <= 1'b0;
      r_eom_seen        <= 1'b0;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_x               <= '0;
      r_c               <= '0;
      r_x_valid         <= 1'b0;
      r_out_eom         <= 1'b0;
      r_learning_recall <= 1'b0;
      r_learning_done   <= 1'b0;
      r_all_done        <= 1'b0;
      r_learn_count     <= '0;
      r_recall_count    <= '0;
      r_err_zero        <= 1'b0;
    end else begin
      r_started <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);

      // Output stage: reload from the FIFO head whenever it is empty or
      // being consumed; otherwise hold x/c stable.
      if (w_pop) begin
        r_x       <= r_mem_vec[w_rd_idx];
        r_c       <= (r_state == ST_LEARN) ? r_mem_cls[w_rd_idx] : 32'd0;
        r_out_eom <= r_mem_eom[w_rd_idx] || w_attach_load;
        r_x_valid <= 1'b1;
      end else if (w_consume) begin
        r_x_valid <= 1'b0;
        r_out_eom <= 1'b0;
      end else if (w_attach_out) begin
        r_out_eom <= 1'b1;
      end

      // Once this phase's eom is accepted, later records wait for the next phase.
      if (w_phase_end) begin
        r_eom_seen <= 1'b0;
      end else if (w_accept && in_eom) begin
        r_eom_seen <= 1'b1;
      end

      if (w_accept && w_zero) r_err_zero <= 1'b1;

      if (w_consume) begin
        if (r_state == ST_LEARN && r_learn_count != '1) begin
          r_learn_count <= r_learn_count + CNT_W'(1);
        end
        if (r_state == ST_RECALL && r_recall_count != '1) begin
          r_recall_count <= r_recall_count + CNT_W'(1);
        end
      end

      case (r_state)
        ST_LEARN: begin
          if (w_phase_end) begin
            r_state           <= ST_RECALL;
            r_learning_done   <= 1'b1;
            r_learning_recall <= 1'b1;
          end
        end
        ST_RECALL: begin
          if (w_phase_end) begin
            r_state    <= ST_DONE;
            r_all_done <= 1'b1;
            r_x_valid  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_x_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  assign x               = r_x;
  assign c               = r_c;
  assign x_valid         = r_x_valid;
  assign learning_recall = r_learning_recall;
  assign learning_done   = r_learning_done;
  assign all_done        = r_all_done;
  assign learn_count     = r_learn_count;
  assign recall_count    = r_recall_count;
  assign err_zero        = r_err_zero;

endmodule
`default_nettype wire

// File: tb/tb_gam_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gam_pattern_loader
// Purpose  : Directed, self-checking bench for gam_pattern_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_gam_pattern_loader;

  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW+31:0] in_data = '0;
  logic          in_eom = 1'b0;
  logic          ml_ready = 1'b0;
  logic [VW-1:0] x;
  logic [31:0]   c;
  logic          x_valid;
  logic          learning_recall;
  logic          learning_done;
  logic          all_done;
  logic [15:0]   learn_count;
  logic [15:0]   recall_count;
  logic          err_zero;

  int checks = 0;
  int errors = 0;

  gam_pattern_loader #(.VECTOR_LEN(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_eom(in_eom), .ml_ready(ml_ready), .x(x), .c(c),
    .x_valid(x_valid), .learning_recall(learning_recall),
    .learning_done(learning_done), .all_done(all_done),
    .learn_count(learn_count), .recall_count(recall_count), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        eom;
    logic [63:0] vec;
    logic [31:0] cls;
    logic        exp_ir;
    logic        exp_xv;
    logic [63:0] exp_x;
    logic [31:0] exp_c;
    logic        exp_ld;
    logic [15:0] exp_lc;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {8{b}};
  endfunction

  task automatic send(input logic [63:0] v, input logic [31:0] cl, input logic e, input string nm);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = {cl, v};
    in_eom   = e;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_eom   = 1'b0;
    chk({nm, "_accepted"}, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    int acc6_cyc;
    bit w;

    // ---------------- reset values ----------------
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_x_valid", 64'(x_valid), 64'd0);
    chk("rst_x", x, 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_flags", {60'd0, learning_recall, learning_done, all_done, err_zero}, 64'd0);
    chk("rst_counts", {32'd0, learn_count, recall_count}, 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // ---------------- A: three learning records, ml_ready=1 ----------------
    tbl[0] = '{1'b1, 1'b0, pat(1), 32'd1, 1'b1, 1'b0, 64'd0,  32'd0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, pat(2), 32'd2, 1'b1, 1'b1, pat(1), 32'd1, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, pat(3), 32'd3, 1'b1, 1'b1, pat(2), 32'd2, 1'b0, 16'd1};
    tbl[3] = '{1'b0, 1'b0, 64'd0,  32'd0, 1'b0, 1'b1, pat(3), 32'd3, 1'b0, 16'd2};
    tbl[4] = '{1'b0, 1'b0, 64'd0,  32'd0, 1'b0, 1'b0, 64'd0,  32'd0, 1'b1, 16'd3};
    tbl[5] = '{1'b0, 1'b0, 64'd0,  32'd0, 1'b1, 1'b0, 64'd0,  32'd0, 1'b1, 16'd3};
    ml_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v;
      in_eom   = tbl[i].eom;
      in_data  = {tbl[i].cls, tbl[i].vec};
      chk($sformatf("A%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ir));
      tick();
      chk($sformatf("A%0d_x_valid", i), 64'(x_valid), 64'(tbl[i].exp_xv));
      if (tbl[i].exp_xv) begin
        chk($sformatf("A%0d_x", i), x, tbl[i].exp_x);
        chk($sformatf("A%0d_c", i), 64'(c), 64'(tbl[i].exp_c));
      end
      chk($sformatf("A%0d_learning_done", i), 64'(learning_done), 64'(tbl[i].exp_ld));
      chk($sformatf("A%0d_learning_recall", i), 64'(learning_recall), 64'(tbl[i].exp_ld));
      chk($sformatf("A%0d_learn_count", i), 64'(learn_count), 64'(tbl[i].exp_lc));
    end
    in_valid = 1'b0;
    in_eom   = 1'b0;

    // ---------------- D: recall phase, class 7 presented as c=0 ----------------
    send(64'hA1A1_A1A1_A1A1_A1A1, 32'd7, 1'b0, "D_r1");
    in_valid = 1'b1;
    in_data  = {32'd7, 64'hB2B2_B2B2_B2B2_B2B2};
    in_eom   = 1'b1;
    chk("D_r2_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_eom   = 1'b0;
    chk("D_x1", x, 64'hA1A1_A1A1_A1A1_A1A1);
    chk("D_c1", 64'(c), 64'd0);
    chk("D_xv1", 64'(x_valid), 64'd1);
    tick();
    chk("D_x2", x, 64'hB2B2_B2B2_B2B2_B2B2);
    chk("D_c2", 64'(c), 64'd0);
    chk("D_rc1", 64'(recall_count), 64'd1);
    tick();
    chk("D_all_done", 64'(all_done), 64'd1);
    chk("D_rc2", 64'(recall_count), 64'd2);
    chk("D_xv_done", 64'(x_valid), 64'd0);
    chk("D_in_ready_done", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = {32'd1, pat(9)};
    tick();
    tick();
    chk("D_in_ready_hold", 64'(in_ready), 64'd0);
    chk("D_rc_hold", 64'(recall_count), 64'd2);
    chk("D_lc_hold", 64'(learn_count), 64'd3);
    in_valid = 1'b0;

    // ---------------- B: back-pressure, 6 records offered ----------------
    do_reset();
    ml_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = 1'b1;
      in_data  = {32'(acc + 1), pat(acc + 1)};
      in_eom   = (acc == 5);
      w = in_ready;
      tick();
      if (w) acc++;
    end
    chk("B_accepted", 64'(acc), 64'd5);
    chk("B_in_ready_full", 64'(in_ready), 64'd0);
    chk("B_x_hold", x, pat(1));
    chk("B_c_hold", 64'(c), 64'd1);
    ml_ready = 1'b1;
    chk("B_no_push_on_pop", 64'(in_ready), 64'd0);
    k = 1;
    acc6_cyc = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (acc < 6) begin
        in_valid = 1'b1;
        in_data  = {32'(acc + 1), pat(acc + 1)};
        in_eom   = (acc == 5);
      end else begin
        in_valid = 1'b0;
        in_eom   = 1'b0;
      end
      if (x_valid) begin
        chk($sformatf("B_order%0d_x", k), x, pat(k));
        chk($sformatf("B_order%0d_c", k), 64'(c), 64'(k));
        k++;
      end
      w = in_valid && in_ready;
      tick();
      if (w) begin
        acc++;
        if (acc == 6) acc6_cyc = cyc;
      end
      if (k > 6) break;
    end
    in_valid = 1'b0;
    in_eom   = 1'b0;
    chk("B_drained", 64'(k), 64'd7);
    chk("B_6th_accept_cycle", 64'(acc6_cyc), 64'd1);
    chk("B_learn_count", 64'(learn_count), 64'd6);
    chk("B_learning_done", 64'(learning_done), 64'd1);

    // ---------------- C: zero filter, then dropped eom with empty FIFO ----------------
    do_reset();
    ml_ready = 1'b1;
    send(pat(17), 32'd0, 1'b0, "C_cls0");
    send(64'd0, 32'd5, 1'b0, "C_vec0");
    chk("C_err_zero", 64'(err_zero), 64'd1);
    tick();
    chk("C_dropped_xv", 64'(x_valid), 64'd0);
    chk("C_dropped_lc", 64'(learn_count), 64'd0);
    send(pat(34), 32'd9, 1'b0, "C_good");
    tick();
    chk("C_good_xv", 64'(x_valid), 64'd1);
    chk("C_good_x", x, pat(34));
    chk("C_good_c", 64'(c), 64'd9);
    tick();
    chk("C_good_lc", 64'(learn_count), 64'd1);
    chk("C_pre_eom_lr", 64'(learning_recall), 64'd0);
    send(64'd0, 32'd1, 1'b1, "C_eom_drop");
    chk("C_eom_lr", 64'(learning_recall), 64'd1);
    chk("C_eom_ld", 64'(learning_done), 64'd1);
    chk("C_eom_lc", 64'(learn_count), 64'd1);
    chk("C_eom_in_ready", 64'(in_ready), 64'd1);

    // ---------------- F: reset with records buffered ----------------
    do_reset();
    ml_ready = 1'b1;
    send(pat(5), 32'd5, 1'b0, "F_r0");
    tick();
    tick();
    chk("F_lc_before", 64'(learn_count), 64'd1);
    ml_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(pat(i), 32'(i), 1'b0, $sformatf("F_r%0d", i));
    chk("F_xv_before", 64'(x_valid), 64'd1);
    chk("F_x_before", x, pat(1));
    reset = 1'b0;
    #1;
    chk("F_async_xv", 64'(x_valid), 64'd0);
    chk("F_async_x", x, 64'd0);
    chk("F_async_lc", 64'(learn_count), 64'd0);
    chk("F_async_in_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("F_after_xv", 64'(x_valid), 64'd0);
    chk("F_after_in_ready", 64'(in_ready), 64'd1);
    ml_ready = 1'b1;
    send(pat(66), 32'd4, 1'b0, "F_restart");
    tick();
    chk("F_restart_x", x, pat(66));
    chk("F_restart_c", 64'(c), 64'd4);
    tick();
    chk("F_restart_lc", 64'(learn_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
